// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four stream bytes into a 32-bit word; word/word_valid are
// combinational so the 4th byte is folded in on the edge it is accepted.
import imem_loader_pkg::*;

module word_packer #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt;
  logic [23:0]   acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (BIG_ENDIAN)
        acc <= {acc[15:0], data};
      else
        acc <= {data, acc[23:8]};
    end
  end

  always_comb begin
    word = BIG_ENDIAN ? {acc, data} : {data, acc};
    word_valid = en && (cnt == CW'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory words,
// holding the CPU while the image is written.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  state_t state;
  state_t next;

  logic [15:0]         n_words;
  logic [15:0]         wcnt;
  logic [ADDR_WIDTH:0] idx;
  logic                xfer;
  logic                begin_s;
  logic                ovf;
  logic                last;
  logic [31:0]         word;
  logic                word_valid;

  assign xfer    = in_valid && in_ready;
  assign begin_s = start && (state == S_IDLE || state == S_DONE);
  assign ovf     = idx[ADDR_WIDTH];
  assign last    = (wcnt == n_words - 16'd1);

  word_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (begin_s),
    .en         (xfer && state == S_DATA),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE,
      S_DONE:   if (begin_s) next = S_HDR_HI;
      S_HDR_HI: if (xfer) next = S_HDR_LO;
      S_HDR_LO: if (xfer)
                  next = ({n_words[15:8], in_data} == 16'd0) ?
                         S_DONE : S_DATA;
      S_DATA:   if (word_valid && last) next = S_FLUSH;
      S_FLUSH:  next = S_DONE;
      default:  next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_HDR_HI,
      S_HDR_LO,
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_FLUSH: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    cpu_hold = busy;
  end

  // idx stops at 2^ADDR_WIDTH, so overflowed words never alias low memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      error         <= 1'b0;
      words_written <= '0;
      n_words       <= '0;
      wcnt          <= '0;
      idx           <= '0;
    end else begin
      mem_we <= 1'b0;
      if (begin_s) begin
        error         <= 1'b0;
        words_written <= '0;
        wcnt          <= '0;
        idx           <= '0;
      end
      if (state == S_HDR_HI && xfer)
        n_words[15:8] <= in_data;
      if (state == S_HDR_LO && xfer)
        n_words[7:0] <= in_data;
      if (word_valid) begin
        wcnt <= wcnt + 16'd1;
        if (ovf) begin
          error <= 1'b1;
        end else begin
          mem_we        <= 1'b1;
          mem_wdata     <= word;
          mem_addr      <= {{(30-ADDR_WIDTH){1'b0}},
                            idx[ADDR_WIDTH-1:0], 2'b00};
          words_written <= words_written + 16'd1;
          idx           <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: three instances share stimulus
// (BE/AW8, LE/AW8, BE/AW2); writes are logged and checked per scenario.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic in_ready0, mem_we0, cpu_hold0, busy0, done0, error0;
  logic [31:0] mem_addr0, mem_wdata0;
  logic [15:0] ww0;
  logic in_ready1, mem_we1, cpu_hold1, busy1, done1, error1;
  logic [31:0] mem_addr1, mem_wdata1;
  logic [15:0] ww1;
  logic in_ready2, mem_we2, cpu_hold2, busy2, done2, error2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [15:0] ww2;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs0[$];
  logic [63:0] obs1[$];
  logic [63:0] obs2[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0),
    .error(error0), .words_written(ww0));

  imem_loader #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1),
    .error(error1), .words_written(ww1));

  imem_loader #(.ADDR_WIDTH(2), .BIG_ENDIAN(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_hold(cpu_hold2), .busy(busy2), .done(done2),
    .error(error2), .words_written(ww2));

  always @(negedge clk) begin
    if (mem_we0) obs0.push_back({mem_addr0, mem_wdata0});
    if (mem_we1) obs1.push_back({mem_addr1, mem_wdata1});
    if (mem_we2) obs2.push_back({mem_addr2, mem_wdata2});
  end

  function automatic logic [31:0] be_word(input logic [7:0] b0,
      input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (in_ready0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready0);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs0.delete();
    obs1.delete();
    obs2.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if ({in_ready0, mem_we0, mem_addr0, mem_wdata0, cpu_hold0, busy0,
         done0, error0, ww0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero want all 0");
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({in_ready0, busy0, cpu_hold0, done0, mem_we0} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 00000",
               {in_ready0, busy0, cpu_hold0, done0, mem_we0});
    end
  endtask

  task automatic test_basic_be();
    logic [7:0] pl[8] = '{8'h3C, 8'h08, 8'h00, 8'h01,
                          8'h3C, 8'h09, 8'h00, 8'h00};
    logic [63:0] e, o;
    clear_logs();
    pulse_start();
    checks++;
    if ({cpu_hold0, busy0, done0} !== 3'b110) begin
      errors++;
      $display("FAIL t1_hold_at_start got %b want 110",
               {cpu_hold0, busy0, done0});
    end
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    exp_q.push_back({32'h0, 32'h3C080001});
    exp_q.push_back({32'h4, 32'h3C090000});
    for (int i = 0; i < 8; i++) send_byte(pl[i], 0);
    checks++;
    if ({mem_we0, done0, cpu_hold0} !== 3'b101) begin
      errors++;
      $display("FAIL t1_write_cycle we/done/hold got %b want 101",
               {mem_we0, done0, cpu_hold0});
    end
    tick();
    checks++;
    if ({mem_we0, done0, cpu_hold0, busy0} !== 4'b0100) begin
      errors++;
      $display("FAIL t1_done_latency we/done/hold/busy got %b want 0100",
               {mem_we0, done0, cpu_hold0, busy0});
    end
    repeat (3) tick();
    checks++;
    if (ww0 !== 16'd2 || error0 !== 1'b0) begin
      errors++;
      $display("FAIL t1_count ww=%0d err=%b want 2 0", ww0, error0);
    end
    checks++;
    if (obs0.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t1_nwrites got %0d want %0d", obs0.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs0.size() > 0) begin
      e = exp_q.pop_front();
      o = obs0.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t1_write got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_little_endian();
    logic [7:0] pl[4] = '{8'h01, 8'h00, 8'h08, 8'h3C};
    logic [63:0] e, o;
    clear_logs();
    pulse_start();
    checks++;
    if ({done1, ww1, error1} !== 18'b0) begin
      errors++;
      $display("FAIL t2_restart_clear done=%b ww=%0d want 0 0", done1, ww1);
    end
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    exp_q.push_back({32'h0, 32'h3C080001});
    for (int i = 0; i < 4; i++) send_byte(pl[i], 0);
    repeat (3) tick();
    checks++;
    if (obs1.size() != 1 || done1 !== 1'b1 || ww1 !== 16'd1) begin
      errors++;
      $display("FAIL t2_le_summary n=%0d done=%b ww=%0d want 1 1 1",
               obs1.size(), done1, ww1);
    end
    while (exp_q.size() > 0 && obs1.size() > 0) begin
      e = exp_q.pop_front();
      o = obs1.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t2_le_write got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if ({done0, busy0, mem_we0, error0} !== 4'b1000) begin
      errors++;
      $display("FAIL t3_zero_done got %b want 1000",
               {done0, busy0, mem_we0, error0});
    end
    repeat (3) tick();
    checks++;
    if (obs0.size() != 0 || ww0 !== 16'd0) begin
      errors++;
      $display("FAIL t3_zero_nowrite n=%0d ww=%0d want 0 0",
               obs0.size(), ww0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[4];
    logic [63:0] e, o;
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'(16 * w + k + 1);
      if (w < 4) exp_q.push_back({32'(w * 4), be_word(b[0], b[1], b[2], b[3])});
      for (int k = 0; k < 4; k++) send_byte(b[k], 0);
    end
    repeat (3) tick();
    checks++;
    if (error2 !== 1'b1 || ww2 !== 16'd4 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL t4_ovf_flags err=%b ww=%0d done=%b want 1 4 1",
               error2, ww2, done2);
    end
    checks++;
    if (error0 !== 1'b0 || ww0 !== 16'd5) begin
      errors++;
      $display("FAIL t4_big_mem err=%b ww=%0d want 0 5", error0, ww0);
    end
    checks++;
    if (obs2.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t4_nwrites got %0d want %0d", obs2.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs2.size() > 0) begin
      e = exp_q.pop_front();
      o = obs2.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t4_write got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic [7:0] b[12];
    logic [63:0] e, o;
    clear_logs();
    for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
    for (int w = 0; w < 3; w++)
      exp_q.push_back({32'(w * 4),
        be_word(b[4*w], b[4*w+1], b[4*w+2], b[4*w+3])});
    pulse_start();
    send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'h03, $urandom_range(0, 3));
    for (int i = 0; i < 12; i++) begin
      send_byte(b[i], $urandom_range(0, 3));
      if (i == 5) pulse_start();
    end
    repeat (4) tick();
    checks++;
    if (done0 !== 1'b1 || ww0 !== 16'd3) begin
      errors++;
      $display("FAIL t5_gaps_summary done=%b ww=%0d want 1 3", done0, ww0);
    end
    checks++;
    if (obs0.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t5_nwrites got %0d want %0d", obs0.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs0.size() > 0) begin
      e = exp_q.pop_front();
      o = obs0.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t5_write got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[6];
    logic [7:0] c[4];
    logic [63:0] e, o;
    clear_logs();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) c[i] = 8'($urandom);
    exp_q.push_back({32'h0, be_word(b[0], b[1], b[2], b[3])});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 6; i++) send_byte(b[i], 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready0, mem_we0, mem_addr0, mem_wdata0, cpu_hold0, busy0,
         done0, error0, ww0} !== '0) begin
      errors++;
      $display("FAIL t6_reset_outputs busy=%b ww=%0d want all 0",
               busy0, ww0);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back({32'h0, be_word(c[0], c[1], c[2], c[3])});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 4; i++) send_byte(c[i], 0);
    repeat (3) tick();
    checks++;
    if (done0 !== 1'b1 || ww0 !== 16'd1) begin
      errors++;
      $display("FAIL t6_reload done=%b ww=%0d want 1 1", done0, ww0);
    end
    checks++;
    if (obs0.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t6_nwrites got %0d want %0d", obs0.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs0.size() > 0) begin
      e = exp_q.pop_front();
      o = obs0.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL t6_write got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_be();
    test_little_endian();
    test_zero_len();
    test_overflow();
    test_random_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached want finish earlier");
    $fatal(1, "timeout");
  end

endmodule
